// File: rtl/char_hp_ctrl.sv
// Per-player health controller: body-contact detection, projectile hits, invulnerability and death.
// Optional passive regeneration is enabled by defining CHAR_HP_REGEN_EN.
module char_hp_ctrl #(
    parameter int unsigned MAX_HP        = 4,
    parameter int unsigned CONTACT_DMG   = 1,
    parameter int unsigned SHOT_DMG      = 1,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned REGEN_FRAMES  = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [1:0]  game_active,
    input  logic        game_start,
    input  logic [11:0] char_x,
    input  logic [11:0] char_y,
    input  logic [11:0] char_lng,
    input  logic [11:0] char_hgt,
    input  logic [11:0] boss_x,
    input  logic [11:0] boss_y,
    input  logic [11:0] boss_lng,
    input  logic [11:0] boss_hgt,
    input  logic        boss_hit,
    output logic [3:0]  char_hp,
    output logic        dead,
    output logic        hit_flash,
    output logic        damage_pulse
);

    // state     | meaning
    // ST_IDLE   | before the first game_start, no damage taken
    // ST_ALIVE  | fight running, contact and shots apply damage
    // ST_INVULN | post-hit grace window, inv_cnt counts down per frame
    // ST_DEAD   | health exhausted, waits for game_start
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIVE  = 2'd1,
        ST_INVULN = 2'd2,
        ST_DEAD   = 2'd3
    } state_t;

    localparam logic [3:0] HP_MAX  = 4'(MAX_HP);
    localparam logic [4:0] C_DMG   = 5'(CONTACT_DMG);
    localparam logic [4:0] S_DMG   = 5'(SHOT_DMG);
    localparam logic [7:0] INV_TC  = 8'(INVULN_FRAMES);

    state_t      state_q, state_d;
    logic [3:0]  hp_q, hp_d;
    logic [7:0]  inv_cnt_q, inv_cnt_d;
    logic        pending_q, pending_d;
    logic        contact_q, contact_d;
    logic        pulse_q, pulse_d;

`ifdef CHAR_HP_REGEN_EN
    localparam logic [9:0] REGEN_TC = 10'(REGEN_FRAMES);
    logic [9:0]  regen_cnt_q, regen_cnt_d;
    logic [9:0]  regen_inc;
`endif

    logic [12:0] dx, dy, sum_x, sum_y;
    logic        active;
    logic        shot;
    logic [4:0]  dmg;

    // Distances are folded to magnitudes so the overlap test is a plain compare.
    always_comb begin
        if (char_x >= boss_x) dx = {1'b0, char_x} - {1'b0, boss_x};
        else                  dx = {1'b0, boss_x} - {1'b0, char_x};
        if (char_y >= boss_y) dy = {1'b0, char_y} - {1'b0, boss_y};
        else                  dy = {1'b0, boss_y} - {1'b0, char_y};
        sum_x     = {1'b0, char_lng} + {1'b0, boss_lng};
        sum_y     = {1'b0, char_hgt} + {1'b0, boss_hgt};
        contact_d = (dx < sum_x) && (dy < sum_y);
    end

    assign active = (game_active == 2'b01);
    // A hit arriving on the tick itself still counts for that tick.
    assign shot   = pending_q | boss_hit;
    assign dmg    = (contact_q ? C_DMG : 5'd0) + (shot ? S_DMG : 5'd0);

    always_comb begin
        state_d   = state_q;
        hp_d      = hp_q;
        inv_cnt_d = inv_cnt_q;
        pending_d = pending_q;
        pulse_d   = 1'b0;
`ifdef CHAR_HP_REGEN_EN
        regen_cnt_d = regen_cnt_q;
        regen_inc   = (regen_cnt_q >= REGEN_TC) ? REGEN_TC : regen_cnt_q + 10'd1;
`endif

        if (game_start) begin
            state_d   = ST_ALIVE;
            hp_d      = HP_MAX;
            inv_cnt_d = 8'd0;
            pending_d = 1'b0;
`ifdef CHAR_HP_REGEN_EN
            regen_cnt_d = 10'd0;
`endif
        end else if (!active) begin
            pending_d = 1'b0;
        end else begin
            if (frame_tick)    pending_d = 1'b0;
            else if (boss_hit) pending_d = 1'b1;

            if (frame_tick) begin
                case (state_q)
                    ST_ALIVE: begin
                        if (dmg != 5'd0) begin
                            pulse_d = 1'b1;
`ifdef CHAR_HP_REGEN_EN
                            regen_cnt_d = 10'd0;
`endif
                            if ({1'b0, hp_q} <= dmg) begin
                                hp_d    = 4'd0;
                                state_d = ST_DEAD;
                            end else begin
                                hp_d      = hp_q - dmg[3:0];
                                state_d   = ST_INVULN;
                                inv_cnt_d = INV_TC;
                            end
                        end else begin
`ifdef CHAR_HP_REGEN_EN
                            if (regen_inc == REGEN_TC && hp_q < HP_MAX) begin
                                hp_d        = hp_q + 4'd1;
                                regen_cnt_d = 10'd0;
                            end else begin
                                regen_cnt_d = regen_inc;
                            end
`endif
                        end
                    end
                    ST_INVULN: begin
                        if (inv_cnt_q <= 8'd1) begin
                            inv_cnt_d = 8'd0;
                            state_d   = ST_ALIVE;
                        end else begin
                            inv_cnt_d = inv_cnt_q - 8'd1;
                        end
                    end
                    ST_DEAD: hp_d = 4'd0;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hp_q      <= HP_MAX;
            inv_cnt_q <= 8'd0;
            pending_q <= 1'b0;
            contact_q <= 1'b0;
            pulse_q   <= 1'b0;
`ifdef CHAR_HP_REGEN_EN
            regen_cnt_q <= 10'd0;
`endif
        end else begin
            state_q   <= state_d;
            hp_q      <= hp_d;
            inv_cnt_q <= inv_cnt_d;
            pending_q <= pending_d;
            contact_q <= contact_d;
            pulse_q   <= pulse_d;
`ifdef CHAR_HP_REGEN_EN
            regen_cnt_q <= regen_cnt_d;
`endif
        end
    end

    assign char_hp      = hp_q;
    assign dead         = (state_q == ST_DEAD);
    assign hit_flash    = (state_q == ST_INVULN) && inv_cnt_q[2];
    assign damage_pulse = pulse_q;

endmodule

// File: tb/tb_char_hp_ctrl.sv
// Directed bench for char_hp_ctrl in its default build (default parameters, no regeneration).
module tb_char_hp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [1:0]  game_active;
    logic        game_start;
    logic [11:0] char_x, char_y, char_lng, char_hgt;
    logic [11:0] boss_x, boss_y, boss_lng, boss_hgt;
    logic        boss_hit;
    logic [3:0]  char_hp;
    logic        dead, hit_flash, damage_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;

    always #5 clk = ~clk;

    char_hp_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
        .game_start(game_start),
        .char_x(char_x), .char_y(char_y), .char_lng(char_lng), .char_hgt(char_hgt),
        .boss_x(boss_x), .boss_y(boss_y), .boss_lng(boss_lng), .boss_hgt(boss_hgt),
        .boss_hit(boss_hit), .char_hp(char_hp), .dead(dead), .hit_flash(hit_flash),
        .damage_pulse(damage_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each pulse task returns on the negedge right after the updating edge.
    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic shot_tick();
        @(negedge clk) begin frame_tick = 1'b1; boss_hit = 1'b1; end
        @(negedge clk) begin frame_tick = 1'b0; boss_hit = 1'b0; end
    endtask

    task automatic hit_pulse();
        @(negedge clk) boss_hit = 1'b1;
        @(negedge clk) boss_hit = 1'b0;
    endtask

    task automatic start_game();
        @(negedge clk) game_start = 1'b1;
        @(negedge clk) game_start = 1'b0;
    endtask

    task automatic set_pos(input int cx, input int cy, input int cl, input int ch,
                           input int bx, input int by, input int bl, input int bh);
        char_x = 12'(cx); char_y = 12'(cy); char_lng = 12'(cl); char_hgt = 12'(ch);
        boss_x = 12'(bx); boss_y = 12'(by); boss_lng = 12'(bl); boss_hgt = 12'(bh);
    endtask

    task automatic ticks_count(input int n);
        repeat (n) begin
            tick();
            pulses += int'(damage_pulse);
        end
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; game_active = 2'b01; game_start = 1'b0; boss_hit = 1'b0;
        set_pos(100, 100, 16, 16, 1000, 100, 32, 32);
        idle(3);
        check("rst_hp", 32'(char_hp), 4);
        check("rst_dead", 32'(dead), 0);
        check("rst_flash", 32'(hit_flash), 0);
        check("rst_pulse", 32'(damage_pulse), 0);
        @(negedge clk) rst = 1'b0;

        // IDLE ignores contact
        set_pos(100, 100, 16, 16, 120, 100, 32, 32);
        idle(2);
        tick();
        check("idle_no_dmg", 32'(char_hp), 4);

        // contact hit, invulnerability window, second hit on tick 62
        start_game();
        check("start_hp", 32'(char_hp), 4);
        tick();
        check("contact_hp", 32'(char_hp), 3);
        check("contact_pulse", 32'(damage_pulse), 1);
        check("flash_inv60", 32'(hit_flash), 1);
        idle(1);
        check("pulse_one_cycle", 32'(damage_pulse), 0);
        tick();
        check("flash_inv59", 32'(hit_flash), 0);
        pulses = 0;
        for (int i = 3; i <= 61; i++) begin
            tick();
            pulses += int'(damage_pulse);
            if (i == 6) check("flash_inv55", 32'(hit_flash), 1);
        end
        check("invuln_hp", 32'(char_hp), 3);
        check("invuln_pulses", 32'(pulses), 0);
        check("invuln_over_flash", 32'(hit_flash), 0);
        tick();
        check("tick62_hp", 32'(char_hp), 2);
        check("tick62_pulse", 32'(damage_pulse), 1);

        // touching edges are not contact; one pixel closer is
        set_pos(100, 100, 16, 16, 148, 100, 32, 32);
        start_game();
        pulses = 0;
        ticks_count(10);
        check("edge_x_hp", 32'(char_hp), 4);
        check("edge_x_pulses", 32'(pulses), 0);
        boss_x = 12'd147;
        idle(1);
        tick();
        check("overlap_x_hp", 32'(char_hp), 3);

        set_pos(200, 100, 16, 16, 190, 52, 32, 32);
        start_game();
        tick();
        check("edge_y_hp", 32'(char_hp), 4);
        boss_y = 12'd53;
        idle(1);
        tick();
        check("overlap_y_hp", 32'(char_hp), 3);

        // projectile hits, ignored during invulnerability
        set_pos(100, 100, 16, 16, 1000, 100, 32, 32);
        start_game();
        hit_pulse();
        idle(4);
        tick();
        check("shot_hp", 32'(char_hp), 3);
        check("shot_pulse", 32'(damage_pulse), 1);
        hit_pulse();
        tick();
        check("shot_invuln_hp", 32'(char_hp), 3);
        repeat (59) tick();
        tick();
        check("pending_cleared", 32'(char_hp), 3);
        shot_tick();
        check("same_cycle_shot", 32'(char_hp), 2);

        // combined damage at hp=1 saturates to zero
        start_game();
        shot_tick();
        repeat (60) tick();
        shot_tick();
        repeat (60) tick();
        shot_tick();
        check("hp_one", 32'(char_hp), 1);
        repeat (60) tick();
        set_pos(100, 100, 16, 16, 120, 100, 32, 32);
        idle(1);
        shot_tick();
        check("sat_hp", 32'(char_hp), 0);
        check("sat_dead", 32'(dead), 1);
        check("sat_pulse", 32'(damage_pulse), 1);
        pulses = 0;
        repeat (3) begin
            shot_tick();
            pulses += int'(damage_pulse);
        end
        check("dead_hp", 32'(char_hp), 0);
        check("dead_stays", 32'(dead), 1);
        check("dead_pulses", 32'(pulses), 0);
        start_game();
        check("restart_hp", 32'(char_hp), 4);
        check("restart_dead", 32'(dead), 0);

        // freeze: no damage, hits during freeze discarded
        start_game();
        @(negedge clk) game_active = 2'b10;
        pulses = 0;
        ticks_count(100);
        check("freeze_hp", 32'(char_hp), 4);
        check("freeze_pulses", 32'(pulses), 0);
        hit_pulse();
        set_pos(100, 100, 16, 16, 1000, 100, 32, 32);
        idle(1);
        @(negedge clk) game_active = 2'b01;
        tick();
        check("freeze_hit_dropped", 32'(char_hp), 4);
        set_pos(100, 100, 16, 16, 120, 100, 32, 32);
        idle(1);
        tick();
        check("unfreeze_hp", 32'(char_hp), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
